// File: rtl/str_pkg.sv
// Shared definitions for the string packer.
// Character width, default terminator and FSM state encoding.
package str_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] DEFAULT_TERM = 8'h0A;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/str_packer.sv
// Byte-serial to packed-string converter.
// Chars shift in from the right; the terminator presents the string.
module str_packer
    import str_pkg::*;
#(
    parameter int                MAX_CHARS = 13,
    parameter logic [CHAR_W-1:0] TERM_CHAR = DEFAULT_TERM,
    parameter int                LEN_W     = $clog2(MAX_CHARS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHAR_W-1:0]           in_char,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MAX_CHARS*CHAR_W-1:0] out_str,
    output logic [LEN_W-1:0]            out_len,
    output logic                        out_trunc
);

    localparam int STR_W = MAX_CHARS * CHAR_W;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_CHARS);

    state_t           state_q;
    state_t           state_n;
    logic [STR_W-1:0] str_q;
    logic [STR_W-1:0] str_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_n;
    logic             trunc_q;
    logic             trunc_n;
    logic             in_ready_q;
    logic             in_ready_n;
    logic             out_valid_q;
    logic             out_valid_n;

    // Next state and datapath: accept, drop or close in FILL; clear on handshake.
    always_comb begin
        state_n = state_q;
        str_n   = str_q;
        len_n   = len_q;
        trunc_n = trunc_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (in_char == TERM_CHAR) begin
                        state_n = HOLD;
                    end else if (len_q < LEN_MAX) begin
                        str_n = (str_q << CHAR_W) | STR_W'(in_char);
                        len_n = len_q + 1'b1;
                    end else begin
                        trunc_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = FILL;
                    str_n   = '0;
                    len_n   = '0;
                    trunc_n = 1'b0;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
        in_ready_n  = (state_n == FILL);
        out_valid_n = (state_n == HOLD);
    end

    // Register state, datapath and handshake outputs together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            str_q       <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            str_q       <= str_n;
            len_q       <= len_n;
            trunc_q     <= trunc_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_str   = str_q;
    assign out_len   = len_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_str_packer.sv
// Directed bench for str_packer.
// Hand-computed vectors for packing, truncation, stalls and reset.
module tb_str_packer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_char;
    logic         out_valid;
    logic         out_ready;
    logic [103:0] out_str;
    logic [3:0]   out_len;
    logic         out_trunc;

    int passed;
    int total;

    str_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_str   (out_str),
        .out_len   (out_len),
        .out_trunc (out_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_char  = c;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_len", out_len, 0);
        check("rst_str", out_str, 0);
        check("rst_trunc", out_trunc, 0);
        rst = 1'b0;
        tick();

        out_ready = 1'b1;
        send_str("hello world");
        send_char(8'h0A);
        check("hw_valid", out_valid, 1);
        check("hw_len", out_len, 11);
        check("hw_trunc", out_trunc, 0);
        check("hw_str", out_str, 104'h68656c6c6f20776f726c64);
        check("hw_top", out_str[103:64], 40'h000068656c);
        tick();
        out_ready = 1'b0;
        check("hw_clr_valid", out_valid, 0);
        check("hw_clr_len", out_len, 0);
        check("hw_clr_ready", in_ready, 1);

        send_str("ABCDEFGHIJKLM");
        send_char(8'h0A);
        check("full_len", out_len, 13);
        check("full_trunc", out_trunc, 0);
        handshake();

        send_str("ABCDEFGHIJKLMNO");
        send_char(8'h0A);
        check("tr_valid", out_valid, 1);
        check("tr_len", out_len, 13);
        check("tr_trunc", out_trunc, 1);
        check("tr_str", out_str, 104'h4142434445464748494a4b4c4d);
        handshake();
        check("tr_clr_trunc", out_trunc, 0);

        send_char(8'h0A);
        check("empty_valid", out_valid, 1);
        check("empty_len", out_len, 0);
        check("empty_str", out_str, 0);
        check("empty_trunc", out_trunc, 0);
        handshake();
        send_str("Hi");
        send_char(8'h0A);
        check("hi_str", out_str, 104'h4869);
        check("hi_len", out_len, 2);
        handshake();

        send_str("OK");
        send_char(8'h0A);
        in_valid = 1'b1;
        in_char  = "X";
        for (int i = 0; i < 5; i++) begin
            check("stall_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_str", out_str, 104'h4f4b);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_hs_valid", out_valid, 0);
        check("stall_hs_len", out_len, 0);
        check("stall_hs_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("x_len", out_len, 1);
        check("x_str", out_str, 104'h58);
        send_char(8'h0A);
        check("x_valid", out_valid, 1);
        handshake();

        send_str("abc");
        check("pre_rst_len", out_len, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_len", out_len, 0);
        check("arst_str", out_str, 0);
        check("arst_ready", in_ready, 1);
        #2 rst = 1'b0;
        tick();
        send_str("d");
        send_char(8'h0A);
        check("d_valid", out_valid, 1);
        check("d_len", out_len, 1);
        check("d_str", out_str, 104'h64);
        handshake();

        for (int i = 0; i < 3; i++) begin
            string s;
            s = "a b";
            repeat (i + 1) tick();
            send_char(s[i]);
        end
        repeat (3) tick();
        check("gap_valid_early", out_valid, 0);
        send_char(8'h0A);
        check("gap_len", out_len, 3);
        check("gap_str", out_str, 104'h612062);
        handshake();
        check("gap_clr", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
